// File: rtl/uio_tx_pkg.sv
// -----------------------------------------------------------------------------
// uio_tx_pkg
// Shared types and constants for the uio_tx serial transmitter.
//   - uio_tx_state_e  : frame state machine encoding
//   - UIO_TX_DATA_BITS: number of data bits per frame
//   - UIO_TX_LINE_IDLE: serial line level when nothing is being sent
// Optional feature macro: UIO_TX_PARITY_EN (adds the even-parity helper).
// -----------------------------------------------------------------------------
package uio_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uio_tx_state_e;

    localparam int unsigned UIO_TX_DATA_BITS = 8;
    localparam logic        UIO_TX_LINE_IDLE = 1'b1;

`ifdef UIO_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UIO_TX_DATA_BITS-1:0] data);
        return ^data;
    endfunction
`endif

endpackage : uio_tx_pkg

// File: rtl/uio_tx_if.sv
// -----------------------------------------------------------------------------
// uio_tx_if
// Byte handshake between the project core (master) and the transmitter (slave).
//   tx_data  [7:0] : byte to send, sampled on accept
//   tx_valid       : core has a byte on tx_data
//   tx_ready       : transmitter accepts a byte this cycle
// -----------------------------------------------------------------------------
interface uio_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface : uio_tx_if

// File: rtl/uio_tx_baud.sv
// -----------------------------------------------------------------------------
// uio_tx_baud
// Bit-time generator. Counts 0..CLKS_PER_BIT-1 and raises bit_done for the one
// cycle in which the count sits at terminal count; the count then wraps to 0.
//   clk      : design clock
//   rst      : synchronous active-high reset
//   clear    : hold the count at 0 (asserted while the transmitter is idle, so
//              every frame starts its first bit-time from a zero count)
//   bit_done : one-cycle strobe at terminal count
// -----------------------------------------------------------------------------
module uio_tx_baud #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int unsigned         CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, terminal count wraps, otherwise increment.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (count_q == TERMINAL) begin
            count_d = {CNT_W{1'b0}};
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_done = (count_q == TERMINAL);

endmodule : uio_tx_baud

// File: rtl/uio_tx.sv
// -----------------------------------------------------------------------------
// uio_tx
// UART-style byte transmitter for the uio pins: start bit (0), 8 data bits
// LSB first, optional even-parity bit, stop bit (1). Line idles high.
//   clk     : design clock (rising edge)
//   rst     : synchronous active-high reset; abandons any frame in progress
//   tx_if   : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx_out  : registered serial line, drives uio_out[0]
//   tx_oe   : output enable for uio_oe[0], high whenever rst is low
//   busy    : a frame is in progress
// Optional feature macro: UIO_TX_PARITY_EN (inserts the parity bit-time).
// -----------------------------------------------------------------------------
module uio_tx
    import uio_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst,
    uio_tx_if.slave  tx_if,
    output logic     tx_out,
    output logic     tx_oe,
    output logic     busy
);

    localparam logic [2:0] LAST_BIT = 3'(UIO_TX_DATA_BITS - 1);

    uio_tx_state_e               state_q;
    uio_tx_state_e               state_d;
    logic [UIO_TX_DATA_BITS-1:0] shift_q;
    logic [UIO_TX_DATA_BITS-1:0] shift_d;
    logic [2:0]                  bit_cnt_q;
    logic [2:0]                  bit_cnt_d;
    logic                        tx_out_q;
    logic                        tx_out_d;
`ifdef UIO_TX_PARITY_EN
    logic                        parity_q;
    logic                        parity_d;
`endif
    logic                        accept_s;
    logic                        bit_done_s;
    logic                        idle_s;

    assign idle_s         = (state_q == ST_IDLE);
    assign tx_if.tx_ready = idle_s && !rst;
    assign accept_s       = tx_if.tx_valid && tx_if.tx_ready;
    assign busy           = !idle_s;
    assign tx_oe          = !rst;
    assign tx_out         = tx_out_q;

    uio_tx_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (idle_s),
        .bit_done (bit_done_s)
    );

    // Frame sequencing, shift register and bit counter next-state.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UIO_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_START;
                    shift_d   = tx_if.tx_data;
                    bit_cnt_d = 3'd0;
`ifdef UIO_TX_PARITY_EN
                    parity_d  = even_parity(tx_if.tx_data);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 3'd0;
`ifdef UIO_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[UIO_TX_DATA_BITS-1:1]};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UIO_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so the registered output
    // shows the start bit in the very first cycle after the accept edge.
    always_comb begin
        tx_out_d = UIO_TX_LINE_IDLE;
        case (state_d)
            ST_IDLE:   tx_out_d = UIO_TX_LINE_IDLE;
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shift_d[0];
`ifdef UIO_TX_PARITY_EN
            ST_PARITY: tx_out_d = parity_d;
`endif
            ST_STOP:   tx_out_d = 1'b1;
            default:   tx_out_d = UIO_TX_LINE_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= {UIO_TX_DATA_BITS{1'b0}};
            bit_cnt_q <= 3'd0;
            tx_out_q  <= UIO_TX_LINE_IDLE;
`ifdef UIO_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_out_q  <= tx_out_d;
`ifdef UIO_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule : uio_tx

// File: doc/uio_tx.md
# uio_tx

Byte-wide UART-style serial transmitter for the Tiny Tapeout user project wrapper. It sits between the project core and the bidirectional `uio` pins. It accepts result bytes from the core over a valid/ready handshake and shifts them out on one `uio` pin as start/data/stop frames. Paired with the core's operand input path, it gives the design an off-chip result channel that does not consume `uo_out`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit-time; legal range 2..65535.

Ports:
- `clk`  input  1  single design clock; all logic is on its rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `tx_data`  input  8  byte to send; sampled only on accept.
- `tx_valid`  input  1  core has a byte on `tx_data`.
- `tx_ready`  output  1  transmitter can accept a byte this cycle.
- `tx_out`  output  1  serial line; idle high; drives `uio_out[0]`.
- `tx_oe`  output  1  output enable for `uio_oe[0]`.
- `busy`  output  1  a frame is in progress (any state other than IDLE).

## Operation
- Accept happens on a rising edge where `tx_valid && tx_ready`. `tx_data` is latched into the shift register on that edge. The core may change `tx_data` afterwards.
- State machine states: IDLE, START, DATA, (PARITY), STOP.
  - IDLE -> START on accept.
  - START -> DATA after one bit-time.
  - DATA -> PARITY or STOP after 8 bit-times, bits sent LSB first.
  - PARITY -> STOP after one bit-time.
  - STOP -> IDLE after one bit-time.
- Line level per state:
  - IDLE: `tx_out`=1.
  - START: `tx_out`=0.
  - DATA: `tx_out` = current shift-register LSB.
  - STOP: `tx_out`=1.
- Bit timing:
  - A bit counter (0..7) tracks the data bits.
  - A cycle counter (0..CLKS_PER_BIT-1) times each bit. It is cleared on every state entry.
- Handshake flags:
  - `tx_ready` = (state==IDLE) && !rst.
  - `busy` = (state!=IDLE).
  - `tx_oe`=1 whenever `rst` is low.
- Reset values (every output, held while `rst`=1):
  - `tx_out`=1, `tx_ready`=0, `busy`=0, `tx_oe`=0.
  - State = IDLE; all counters = 0.
- Reset mid-frame: the frame is abandoned immediately. `tx_out` returns high on the edge where `rst` is sampled. No partial frame resumes after reset.
- `tx_valid` while not ready: ignored. No queuing and no error flag. The core must hold `tx_valid` until it sees `tx_ready`.
- `tx_valid` and `rst` high together: reset wins; the byte is not accepted.

## Timing
- `tx_out` is registered, with no combinational path from the inputs.
- Latency:
  - The start bit appears on `tx_out` in the first cycle after the accept edge.
  - The start bit lasts exactly `CLKS_PER_BIT` cycles, as does every following bit.
- Frame length: 10 bit-times, or 11 with parity.
- IDLE lasts at least one cycle between frames.
  - With `tx_valid` held high continuously, the frame period is 10·CLKS_PER_BIT+1 cycles (11·CLKS_PER_BIT+1 with parity).
  - Between frames `tx_out` is high for CLKS_PER_BIT+1 cycles (stop bit plus the IDLE cycle).
- Counter wrap: the cycle counter is width $clog2(CLKS_PER_BIT). When it reaches terminal count it advances the state; it never free-runs past terminal count.

## Configuration
- `UIO_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - It sends one even-parity bit (XOR of the 8 latched data bits) between the last data bit and STOP.
- `UIO_TX_PARITY_EN` undefined:
  - DATA goes directly to STOP.
  - No parity logic is present.

## Structure
- Package `uio_tx_pkg` holds:
  - the state enum type;
  - `UIO_TX_DATA_BITS`=8;
  - the idle line-level constant.
- Sub-module `uio_tx_baud`:
  - parameterised by `CLKS_PER_BIT`;
  - inputs: `clk`, `rst`, `clear`;
  - output: a one-cycle `bit_done` strobe at terminal count.
- The top level holds the FSM, the shift register, the bit counter and the parity.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Reset:
  - Stimulus: hold `rst`=1 for 3 cycles with `tx_valid`=1.
  - Required: `tx_out`=1, `tx_ready`=0, `tx_oe`=0 throughout; nothing is sent after release unless `tx_valid` is still high.
- Single byte 0xA5:
  - Stimulus: send 0xA5.
  - Required line sequence, 4 cycles per bit: 0 (start), data 1,0,1,0,0,1,0,1, stop 1.
  - Required: `busy` high for exactly 40 cycles; `tx_ready` high again on the next cycle.
- Back-to-back bytes:
  - Stimulus: send 0x00 then 0xFF with `tx_valid` held high.
  - Required: second start bit begins exactly 41 cycles after the first.
- Ignored input:
  - Stimulus: pulse `tx_valid` mid-frame while `tx_ready`=0.
  - Required: the pulse is ignored; the current frame is unchanged.
- Reset mid-frame:
  - Stimulus: assert `rst` during data bit 3.
  - Required: `tx_out`=1 on the next edge; state IDLE after release; no residual bits.
- Parity build (with `UIO_TX_PARITY_EN`):
  - Stimulus: send 0x07.
  - Required: parity bit = 1; frame is 44 cycles.
